// File: rtl/xor_gate_pkg.sv
// xor_gate_pkg
//   Shared constants and types for the xor_gate leaf cell.
//   DEFAULT_WIDTH / DEFAULT_CNT_WIDTH : default parameter values
//   xor_result_t : registered result bundle (y_q, out_valid, parity_q)
//                  at the default width, for consumers of the cell.
package xor_gate_pkg;

    localparam int DEFAULT_WIDTH     = 1;
    localparam int DEFAULT_CNT_WIDTH = 8;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] y_q;
        logic                     out_valid;
        logic                     parity_q;
    } xor_result_t;

endpackage

// File: rtl/xor_gate_if.sv
// xor_gate_if
//   Operand/result bundle of the xor_gate cell.
//   master : drives a, b, in_valid; observes y, y_q, out_valid, parity_q, diff_cnt
//   slave  : the xor_gate side of the same signals
interface xor_gate_if
    import xor_gate_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 in_valid;
    logic [WIDTH-1:0]     y;
    logic [WIDTH-1:0]     y_q;
    logic                 out_valid;
    logic                 parity_q;
    logic [CNT_WIDTH-1:0] diff_cnt;

    modport master (
        output a, b, in_valid,
        input  y, y_q, out_valid, parity_q, diff_cnt
    );

    modport slave (
        input  a, b, in_valid,
        output y, y_q, out_valid, parity_q, diff_cnt
    );
endinterface

// File: rtl/xor_gate_sat_cnt.sv
// xor_gate_sat_cnt
//   Saturating up-counter: counts inc pulses, sticks at all-ones.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
module xor_gate_sat_cnt
    import xor_gate_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/xor_gate.sv
// xor_gate
//   Bitwise XOR of two operands with a combinational result and a
//   one-cycle registered, valid-tagged copy plus its even-parity bit.
//   Optional difference counter built when XOR_GATE_DIFF_CNT_EN is defined;
//   otherwise diff_cnt is tied to zero (port list identical in both builds).
//   clk : clock, rising edge
//   rst : synchronous active-high reset (registered side only)
//   bus : xor_gate_if.slave
//         a, b, in_valid  -> operands and qualifier
//         y               <- a ^ b, combinational
//         y_q, parity_q   <- captured result and its XOR-reduction
//         out_valid       <- one-cycle pulse per accepted input
//         diff_cnt        <- accepted inputs with a != b (saturating)
module xor_gate
    import xor_gate_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    xor_gate_if.slave bus
);

    logic [WIDTH-1:0] diff;

    // No X-masking: unknown operand bits flow straight through to y.
    assign diff  = bus.a ^ bus.b;
    assign bus.y = diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y_q       <= '0;
            bus.parity_q  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y_q      <= diff;
                bus.parity_q <= ^diff;
            end
        end
    end

`ifdef XOR_GATE_DIFF_CNT_EN
    logic diff_inc;

    assign diff_inc = bus.in_valid && (diff != '0);

    xor_gate_sat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_sat_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (diff_inc),
        .count(bus.diff_cnt)
    );
`else
    assign bus.diff_cnt = '0;
`endif

endmodule

// File: tb/tb_xor_gate.sv
module tb_xor_gate;

    typedef struct {
        logic [7:0] y;
        logic       p;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       p;
    } vec_t;

    logic clk;
    logic rst;

    xor_gate_if #(.WIDTH(1), .CNT_WIDTH(2)) if1 ();
    xor_gate_if #(.WIDTH(8), .CNT_WIDTH(8)) if8 ();

    xor_gate #(.WIDTH(1), .CNT_WIDTH(2)) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    xor_gate #(.WIDTH(8), .CNT_WIDTH(8)) u_dut8 (
        .clk(clk),
        .rst(rst),
        .bus(if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q1[$];
    exp_t q8[$];

    logic       h1_y, h1_p;
    logic [7:0] h8_y;
    logic       h8_p;
    logic [1:0] c1;
    logic [7:0] c8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check y combinationally,
    // then check registered outputs #1 after the posedge.
    task automatic cycle(input logic r,
                         input logic iv1, input logic a1v, input logic b1v,
                         input logic iv8, input logic [7:0] a8v, input logic [7:0] b8v);
        exp_t e;
        @(negedge clk);
        rst = r;
        if1.in_valid = iv1; if1.a = a1v; if1.b = b1v;
        if8.in_valid = iv8; if8.a = a8v; if8.b = b8v;
        #1;
        chk("y1_comb", {31'd0, if1.y}, {31'd0, a1v ^ b1v});
        chk("y8_comb", {24'd0, if8.y}, {24'd0, a8v ^ b8v});
        if (r) begin
            q1.delete();
            q8.delete();
        end else begin
            if (iv1) begin
                e.y = {7'd0, a1v ^ b1v};
                e.p = a1v ^ b1v;
                q1.push_back(e);
            end
            if (iv8) begin
                e.y = a8v ^ b8v;
                e.p = ^(a8v ^ b8v);
                q8.push_back(e);
            end
        end
`ifdef XOR_GATE_DIFF_CNT_EN
        if (r) begin
            c1 = '0;
            c8 = '0;
        end else begin
            if (iv1 && (a1v != b1v) && (c1 != 2'd3)) c1 = c1 + 2'd1;
            if (iv8 && (a8v != b8v) && (c8 != 8'hFF)) c8 = c8 + 8'd1;
        end
`else
        c1 = '0;
        c8 = '0;
`endif
        @(posedge clk);
        #1;
        chk("ov1", {31'd0, if1.out_valid}, {31'd0, !r && iv1});
        chk("ov8", {31'd0, if8.out_valid}, {31'd0, !r && iv8});
        if (r) begin
            h1_y = 1'b0; h1_p = 1'b0; h8_y = 8'd0; h8_p = 1'b0;
        end else begin
            if (iv1 && q1.size() > 0) begin
                e = q1.pop_front();
                h1_y = e.y[0];
                h1_p = e.p;
            end
            if (iv8 && q8.size() > 0) begin
                e = q8.pop_front();
                h8_y = e.y;
                h8_p = e.p;
            end
        end
        chk("yq1", {31'd0, if1.y_q}, {31'd0, h1_y});
        chk("par1", {31'd0, if1.parity_q}, {31'd0, h1_p});
        chk("yq8", {24'd0, if8.y_q}, {24'd0, h8_y});
        chk("par8", {31'd0, if8.parity_q}, {31'd0, h8_p});
        chk("cnt1", {30'd0, if1.diff_cnt}, {30'd0, c1});
        chk("cnt8", {24'd0, if8.diff_cnt}, {24'd0, c8});
    endtask

    vec_t v8[6];
    logic [3:0] tt_y;

    initial begin
        v8[0] = '{a: 8'hF0, b: 8'h3C, y: 8'hCC, p: 1'b0};
        v8[1] = '{a: 8'hFF, b: 8'h00, y: 8'hFF, p: 1'b0};
        v8[2] = '{a: 8'h01, b: 8'h00, y: 8'h01, p: 1'b1};
        v8[3] = '{a: 8'hA5, b: 8'hA5, y: 8'h00, p: 1'b0};
        v8[4] = '{a: 8'h80, b: 8'h7F, y: 8'hFF, p: 1'b0};
        v8[5] = '{a: 8'h12, b: 8'h34, y: 8'h26, p: 1'b1};
        tt_y = 4'b0110;

        h1_y = 0; h1_p = 0; h8_y = 0; h8_p = 0; c1 = 0; c8 = 0;
        rst = 1'b1;
        if1.in_valid = 0; if1.a = 0; if1.b = 0;
        if8.in_valid = 0; if8.a = 0; if8.b = 0;

        // 1: combinational truth table, no clock dependence
        for (int i = 0; i < 4; i++) begin
            if1.a = i[1];
            if1.b = i[0];
            #5;
            chk("truth_table", {31'd0, if1.y}, {31'd0, tt_y[i]});
        end

        // 2: reset held two cycles with valid input present
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
        chk("rst_y_comb", {31'd0, if1.y}, 32'd1);

        // 3: single 8-bit capture then hold
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h3C);
        chk("f0_3c_yq", {24'd0, if8.y_q}, 32'hCC);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h0F);
        chk("f0_3c_hold", {24'd0, if8.y_q}, 32'hCC);

        // 4: back-to-back on the 1-bit cell
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("b2b_0", {31'd0, if1.y_q}, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("b2b_1", {31'd0, if1.y_q}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("b2b_2", {31'd0, if1.y_q}, 32'd1);

        // 5: counter saturation with equal pairs interleaved
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 8'h0E);
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h33);
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        end
`ifdef XOR_GATE_DIFF_CNT_EN
        chk("cnt_sat", {30'd0, if1.diff_cnt}, 32'd3);
        chk("cnt8_five", {24'd0, if8.diff_cnt}, 32'd5);
`else
        chk("cnt_tied0", {30'd0, if1.diff_cnt}, 32'd0);
        chk("cnt8_tied0", {24'd0, if8.diff_cnt}, 32'd0);
`endif

        // 6: reset right after a capture drops the result
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h0F);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("drop_yq1", {31'd0, if1.y_q}, 32'd0);
        chk("drop_yq8", {24'd0, if8.y_q}, 32'd0);
        chk("drop_ov8", {31'd0, if8.out_valid}, 32'd0);

        // table-driven 8-bit vectors, with an idle cycle after every other one
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, v8[i].a[0], v8[i].b[0], 1'b1, v8[i].a, v8[i].b);
            chk("tbl_yq", {24'd0, if8.y_q}, {24'd0, v8[i].y});
            chk("tbl_par", {31'd0, if8.parity_q}, {31'd0, v8[i].p});
            if (i % 2 == 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h3C);
        end

        chk("q1_empty", q1.size(), 32'd0);
        chk("q8_empty", q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
